execute_stage: RTL and testbench

//   EX stage of the 5-stage MIPS pipeline: ALU, ALU control, dest-reg select, branch-target adder, EX/MEM latch.

---
 rtl/execute_stage.sv | 237 +++++++++++++++++++++++
 tb/tb_execute_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// ----------------------------------------------------------------------------
// execute_stage
//   EX stage of a 5-stage MIPS pipeline. It contains the ALU and its funct
//   decode, destination-register select, branch-target adder and the EX/MEM
//   pipeline latch. It also holds an iterative unsigned multu/divu unit with
//   HI/LO registers. While that unit is busy the stage stalls upstream and
//   feeds bubbles into MEM.
//
// Ports
//   clk, reset           rising-edge clock, synchronous active-high reset
//   ctlwb_in[1:0]        {regwrite, memtoreg} from ID/EX
//   ctlm_in[2:0]         {branch, memread, memwrite} from ID/EX
//   npc                  PC+4 of the instruction in EX
//   rdata1, rdata2       rs / rt operands (rt is also store data)
//   s_extendout          sign-extended immediate, [5:0] is funct
//   instr_2016/1511      rt / rd register fields
//   alu_op[1:0]          00 add, 01 sub, 10 R-type
//   alu_src, reg_dst     ALU B-operand select, destination select
//   ex_stall             combinational: upstream must hold ID/EX
//   control_wb .. write_reg  registered EX/MEM outputs
// ----------------------------------------------------------------------------
module execute_stage #(
    parameter int WIDTH     = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       ctlwb_in,
    input  logic [2:0]       ctlm_in,
    input  logic [WIDTH-1:0] npc,
    input  logic [WIDTH-1:0] rdata1,
    input  logic [WIDTH-1:0] rdata2,
    input  logic [WIDTH-1:0] s_extendout,
    input  logic [4:0]       instr_2016,
    input  logic [4:0]       instr_1511,
    input  logic [1:0]       alu_op,
    input  logic             alu_src,
    input  logic             reg_dst,
    output logic             ex_stall,
    output logic [1:0]       control_wb,
    output logic             m_ctlout,
    output logic             memread,
    output logic             memwrite,
    output logic [WIDTH-1:0] add_result,
    output logic             zero,
    output logic [WIDTH-1:0] address,
    output logic [WIDTH-1:0] write_data,
    output logic [4:0]       write_reg
);

    localparam int CNT_W = $clog2(MD_CYCLES + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    // Working registers: md_hi is partial product / remainder, md_lo holds
    // the multiplier / dividend being shifted out, md_b the multiplicand /
    // divisor.
    logic [WIDTH-1:0]   md_hi_q, md_hi_d, md_lo_q, md_lo_d, md_b_q, md_b_d;
    logic               md_div_q, md_div_d;

    logic [1:0]         control_wb_q, control_wb_d;
    logic               m_ctl_q, m_ctl_d, memread_q, memread_d;
    logic               memwrite_q, memwrite_d, zero_q, zero_d;
    logic [WIDTH-1:0]   add_result_q, add_result_d, address_q, address_d;
    logic [WIDTH-1:0]   write_data_q, write_data_d;
    logic [4:0]         write_reg_q, write_reg_d;

    logic [5:0]         funct;
    logic [WIDTH-1:0]   alu_b, alu_result;
    logic signed [WIDTH-1:0] s_a, s_b;
    logic               is_md;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0]   step_hi, step_lo;

    assign funct = s_extendout[5:0];
    assign alu_b = alu_src ? s_extendout : rdata2;
    assign s_a   = rdata1;
    assign s_b   = alu_b;
    assign is_md = (alu_op == 2'b10) && ((funct == 6'h19) || (funct == 6'h1B));

    always_comb begin
        alu_result = '0;
        case (alu_op)
            2'b00: alu_result = rdata1 + alu_b;
            2'b01: alu_result = rdata1 - alu_b;
            2'b10: begin
                case (funct)
                    6'h20: alu_result = rdata1 + alu_b;
                    6'h22: alu_result = rdata1 - alu_b;
                    6'h24: alu_result = rdata1 & alu_b;
                    6'h25: alu_result = rdata1 | alu_b;
                    6'h2A: alu_result = {{(WIDTH-1){1'b0}}, (s_a < s_b)};
                    6'h10: alu_result = hi_q;
                    6'h12: alu_result = lo_q;
                    default: alu_result = '0;
                endcase
            end
            default: alu_result = '0;
        endcase
    end

    // One multiply/divide bit per cycle.
    always_comb begin
        // shift-add multiply: add multiplicand when LSB of multiplier set,
        // then shift {hi,lo} right by one
        mul_sum   = {1'b0, md_hi_q} + (md_lo_q[0] ? {1'b0, md_b_q} : '0);
        // restoring divide: shift next dividend bit into remainder, try
        // subtracting the divisor. A zero divisor always "succeeds", which
        // yields all-ones quotient and shifts the dividend into HI.
        div_shift = {md_hi_q, md_lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, md_b_q};
        if (md_div_q) begin
            if (div_shift >= {1'b0, md_b_q}) begin
                step_hi = div_diff[WIDTH-1:0];
                step_lo = {md_lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_shift[WIDTH-1:0];
                step_lo = {md_lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], md_lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        md_hi_d      = md_hi_q;
        md_lo_d      = md_lo_q;
        md_b_d       = md_b_q;
        md_div_d     = md_div_q;
        ex_stall     = 1'b0;
        // EX/MEM defaults to a bubble
        control_wb_d = '0;
        m_ctl_d      = 1'b0;
        memread_d    = 1'b0;
        memwrite_d   = 1'b0;
        add_result_d = '0;
        zero_d       = 1'b0;
        address_d    = '0;
        write_data_d = '0;
        write_reg_d  = '0;
        case (state_q)
            IDLE: begin
                control_wb_d = ctlwb_in;
                m_ctl_d      = ctlm_in[2];
                memread_d    = ctlm_in[1];
                memwrite_d   = ctlm_in[0];
                add_result_d = npc + (s_extendout << 2);
                zero_d       = (alu_result == '0);
                address_d    = alu_result;
                write_data_d = rdata2;
                write_reg_d  = reg_dst ? instr_1511 : instr_2016;
                if (is_md) begin
                    state_d  = BUSY;
                    cnt_d    = CNT_W'(MD_CYCLES - 1);
                    md_div_d = (funct == 6'h1B);
                    md_hi_d  = '0;
                    md_lo_d  = (funct == 6'h1B) ? rdata1 : rdata2;
                    md_b_d   = (funct == 6'h1B) ? rdata2 : rdata1;
                end
            end
            BUSY: begin
                ex_stall = 1'b1;
                md_hi_d  = step_hi;
                md_lo_d  = step_lo;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    // final bit: results land in HI/LO on this edge so the
                    // held instruction sees them next cycle
                    hi_d    = step_hi;
                    lo_d    = step_lo;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            md_hi_q      <= '0;
            md_lo_q      <= '0;
            md_b_q       <= '0;
            md_div_q     <= 1'b0;
            control_wb_q <= '0;
            m_ctl_q      <= 1'b0;
            memread_q    <= 1'b0;
            memwrite_q   <= 1'b0;
            add_result_q <= '0;
            zero_q       <= 1'b0;
            address_q    <= '0;
            write_data_q <= '0;
            write_reg_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            md_hi_q      <= md_hi_d;
            md_lo_q      <= md_lo_d;
            md_b_q       <= md_b_d;
            md_div_q     <= md_div_d;
            control_wb_q <= control_wb_d;
            m_ctl_q      <= m_ctl_d;
            memread_q    <= memread_d;
            memwrite_q   <= memwrite_d;
            add_result_q <= add_result_d;
            zero_q       <= zero_d;
            address_q    <= address_d;
            write_data_q <= write_data_d;
            write_reg_q  <= write_reg_d;
        end
    end

    assign control_wb = control_wb_q;
    assign m_ctlout   = m_ctl_q;
    assign memread    = memread_q;
    assign memwrite   = memwrite_q;
    assign add_result = add_result_q;
    assign zero       = zero_q;
    assign address    = address_q;
    assign write_data = write_data_q;
    assign write_reg  = write_reg_q;

endmodule

// File: tb/tb_execute_stage.sv
// Testbench for execute_stage: every cycle the expected EX/MEM contents are
// pushed to a scoreboard queue before the edge and popped/compared after it.
module tb_execute_stage;

    localparam int W  = 32;
    localparam int OW = 107;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    ctlwb_in;
    logic [2:0]    ctlm_in;
    logic [W-1:0]  npc, rdata1, rdata2, s_extendout;
    logic [4:0]    instr_2016, instr_1511;
    logic [1:0]    alu_op;
    logic          alu_src, reg_dst;
    logic          ex_stall;
    logic [1:0]    control_wb;
    logic          m_ctlout, memread, memwrite, zero;
    logic [W-1:0]  add_result, address, write_data;
    logic [4:0]    write_reg;

    execute_stage #(.WIDTH(W), .MD_CYCLES(32)) dut (
        .clk(clk), .reset(reset), .ctlwb_in(ctlwb_in), .ctlm_in(ctlm_in),
        .npc(npc), .rdata1(rdata1), .rdata2(rdata2), .s_extendout(s_extendout),
        .instr_2016(instr_2016), .instr_1511(instr_1511), .alu_op(alu_op),
        .alu_src(alu_src), .reg_dst(reg_dst), .ex_stall(ex_stall),
        .control_wb(control_wb), .m_ctlout(m_ctlout), .memread(memread),
        .memwrite(memwrite), .add_result(add_result), .zero(zero),
        .address(address), .write_data(write_data), .write_reg(write_reg)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [OW-1:0] sb_q[$];

    // reference model state
    logic          mbusy = 1'b0;
    int            mcnt  = 0;
    logic [W-1:0]  mhi = '0, mlo = '0, phi = '0, plo = '0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [OW-1:0] observed();
        return {control_wb, m_ctlout, memread, memwrite, add_result, zero,
                address, write_data, write_reg};
    endfunction

    task automatic drive(input logic [1:0] cwb, input logic [2:0] cm, input logic [W-1:0] pc,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] imm,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [1:0] op,
                         input logic src, input logic dst);
        ctlwb_in = cwb; ctlm_in = cm; npc = pc; rdata1 = a; rdata2 = b;
        s_extendout = imm; instr_2016 = rt; instr_1511 = rd; alu_op = op;
        alu_src = src; reg_dst = dst;
    endtask

    // one clock: model the expected EX/MEM, push, clock, pop and compare
    task automatic step(input string tag);
        logic [W-1:0]  b, res;
        logic [63:0]   prod;
        logic [OW-1:0] e;
        check({tag, "_stall"}, ex_stall, mbusy);
        e = '0;
        if (mbusy) begin
            mcnt--;
            if (mcnt == 0) begin
                mbusy = 1'b0;
                mhi = phi;
                mlo = plo;
            end
        end else begin
            b = alu_src ? s_extendout : rdata2;
            res = '0;
            if (alu_op == 2'b00) res = rdata1 + b;
            else if (alu_op == 2'b01) res = rdata1 - b;
            else if (alu_op == 2'b10) begin
                case (s_extendout[5:0])
                    6'h20: res = rdata1 + b;
                    6'h22: res = rdata1 - b;
                    6'h24: res = rdata1 & b;
                    6'h25: res = rdata1 | b;
                    6'h2A: res = ($signed(rdata1) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h10: res = mhi;
                    6'h12: res = mlo;
                    6'h19: begin
                        prod = {32'd0, rdata1} * {32'd0, rdata2};
                        phi = prod[63:32]; plo = prod[31:0];
                        mbusy = 1'b1; mcnt = 32;
                    end
                    6'h1B: begin
                        if (rdata2 == 0) begin phi = rdata1; plo = 32'hFFFFFFFF; end
                        else begin phi = rdata1 % rdata2; plo = rdata1 / rdata2; end
                        mbusy = 1'b1; mcnt = 32;
                    end
                    default: res = '0;
                endcase
            end
            e = {ctlwb_in, ctlm_in, npc + (s_extendout << 2), (res == 0),
                 res, rdata2, reg_dst ? instr_1511 : instr_2016};
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) check({tag, "_sb_empty"}, 1, 0);
        else check(tag, observed(), sb_q.pop_front());
    endtask

    // hold the instruction upstream while the model says the unit is busy
    task automatic issue(input string tag, output int stalls);
        stalls = 0;
        while (mbusy && stalls < 100) begin
            step({tag, "_bubble"});
            stalls++;
        end
        if (mbusy) check({tag, "_hold_timeout"}, 1, 0);
        step(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        reset = 1'b1;
        drive(2'b11, 3'b111, 32'h40, 32'h55, 32'h66, 32'h20, 5'd3, 5'd4, 2'b10, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", observed(), '0);
        check("reset_stall", ex_stall, 0);
        reset = 1'b0;

        // lw
        drive(2'b11, 3'b010, 32'h0, 32'h100, 32'hAA, 32'h8, 5'd5, 5'd7, 2'b00, 1'b1, 1'b0);
        issue("lw", st);
        check("lw_addr", address, 32'h108);
        check("lw_wreg", write_reg, 5'd5);
        // beq
        drive(2'b00, 3'b100, 32'h40, 32'h1234, 32'h1234, 32'h3, 5'd1, 5'd2, 2'b01, 1'b0, 1'b0);
        issue("beq", st);
        check("beq_tgt", add_result, 32'h4C);
        check("beq_zero", zero, 1);
        // slt signed, and, or, add/sub wrap, unknown funct, ID bubble
        drive(2'b10, 3'b000, 32'h80, 32'hFFFFFFFF, 32'h1, 32'h2A, 5'd1, 5'd9, 2'b10, 1'b0, 1'b1);
        issue("slt", st);
        check("slt_res", address, 32'h1);
        drive(2'b10, 3'b000, 32'h84, 32'hF0F0, 32'h0FF0, 32'h24, 5'd1, 5'd10, 2'b10, 1'b0, 1'b1);
        issue("and", st);
        check("and_res", address, 32'hF0);
        drive(2'b10, 3'b000, 32'h88, 32'hF0F0, 32'h0FF0, 32'h25, 5'd1, 5'd11, 2'b10, 1'b0, 1'b1);
        issue("or", st);
        drive(2'b10, 3'b000, 32'h8C, 32'hFFFFFFFF, 32'h2, 32'h20, 5'd1, 5'd12, 2'b10, 1'b0, 1'b1);
        issue("add_wrap", st);
        drive(2'b10, 3'b000, 32'h90, 32'h0, 32'h1, 32'h22, 5'd1, 5'd13, 2'b10, 1'b0, 1'b1);
        issue("sub_wrap", st);
        drive(2'b10, 3'b001, 32'h94, 32'h7, 32'h9, 32'h3F, 5'd1, 5'd14, 2'b10, 1'b0, 1'b1);
        issue("bad_funct", st);
        drive(2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        issue("id_bubble", st);
        // random R-type add/sub/and/or/slt
        for (int i = 0; i < 8; i++) begin
            logic [31:0] fsel;
            fsel = 32'h20 | 32'($urandom_range(0, 5));
            if (fsel == 32'h21 || fsel == 32'h23) fsel = 32'h2A;
            drive(2'b10, 3'b000, $urandom, $urandom, $urandom, fsel, 5'd1, 5'($urandom), 2'b10, 1'b0, 1'b1);
            issue("rand_r", st);
        end

        // multu, then mflo held upstream
        drive(2'b00, 3'b000, 32'h100, 32'h10000, 32'h30000, 32'h19, 5'd1, 5'd0, 2'b10, 1'b0, 1'b1);
        issue("multu", st);
        drive(2'b10, 3'b000, 32'h104, 32'h0, 32'h0, 32'h12, 5'd0, 5'd15, 2'b10, 1'b0, 1'b1);
        issue("mflo_mul", st);
        check("mul_stall_cycles", st, 32);
        check("mflo_mul_val", address, 32'h0);
        drive(2'b10, 3'b000, 32'h108, 32'h0, 32'h0, 32'h10, 5'd0, 5'd16, 2'b10, 1'b0, 1'b1);
        issue("mfhi_mul", st);
        check("mfhi_mul_val", address, 32'h3);

        // divu 100/7
        drive(2'b00, 3'b000, 32'h10C, 32'd100, 32'd7, 32'h1B, 5'd1, 5'd0, 2'b10, 1'b0, 1'b1);
        issue("divu", st);
        drive(2'b10, 3'b000, 32'h110, 32'h0, 32'h0, 32'h12, 5'd0, 5'd17, 2'b10, 1'b0, 1'b1);
        issue("mflo_div", st);
        check("mflo_div_val", address, 32'd14);
        drive(2'b10, 3'b000, 32'h114, 32'h0, 32'h0, 32'h10, 5'd0, 5'd18, 2'b10, 1'b0, 1'b1);
        issue("mfhi_div", st);
        check("mfhi_div_val", address, 32'd2);
        // divu 5/0, stall still full length
        drive(2'b00, 3'b000, 32'h118, 32'd5, 32'd0, 32'h1B, 5'd1, 5'd0, 2'b10, 1'b0, 1'b1);
        issue("divu0", st);
        drive(2'b10, 3'b000, 32'h11C, 32'h0, 32'h0, 32'h10, 5'd0, 5'd19, 2'b10, 1'b0, 1'b1);
        issue("mfhi_div0", st);
        check("div0_stall_cycles", st, 32);
        check("mfhi_div0_val", address, 32'd5);
        drive(2'b10, 3'b000, 32'h120, 32'h0, 32'h0, 32'h12, 5'd0, 5'd20, 2'b10, 1'b0, 1'b1);
        issue("mflo_div0", st);
        check("mflo_div0_val", address, 32'hFFFFFFFF);
        // multu of large values
        drive(2'b00, 3'b000, 32'h124, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h19, 5'd1, 5'd0, 2'b10, 1'b0, 1'b1);
        issue("multu_big", st);
        drive(2'b10, 3'b000, 32'h128, 32'h0, 32'h0, 32'h10, 5'd0, 5'd21, 2'b10, 1'b0, 1'b1);
        issue("mfhi_big", st);

        // reset during BUSY cycle 10
        drive(2'b00, 3'b000, 32'h200, 32'd1000, 32'd3, 32'h1B, 5'd1, 5'd0, 2'b10, 1'b0, 1'b1);
        issue("divu_rst", st);
        drive(2'b10, 3'b000, 32'h204, 32'h0, 32'h0, 32'h10, 5'd0, 5'd22, 2'b10, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step("busy_pre_rst");
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_out", observed(), '0);
        check("midrst_stall", ex_stall, 0);
        reset = 1'b0;
        mbusy = 1'b0; mcnt = 0; mhi = '0; mlo = '0;
        sb_q.delete();
        issue("mfhi_after_rst", st);
        check("mfhi_after_rst_val", address, 32'h0);
        drive(2'b10, 3'b000, 32'h208, 32'h0, 32'h0, 32'h12, 5'd0, 5'd23, 2'b10, 1'b0, 1'b1);
        issue("mflo_after_rst", st);
        drive(2'b10, 3'b000, 32'h20C, 32'd21, 32'd21, 32'h20, 5'd1, 5'd24, 2'b10, 1'b0, 1'b1);
        issue("add_after_rst", st);
        check("add_after_rst_val", address, 32'd42);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
